semaforo_intersection_ctrl: RTL and testbench



---
 rtl/semaforo_pkg.sv | 30 +++
 rtl/semaforo_tick_gen.sv | 33 +++
 rtl/semaforo_intersection_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_semaforo_intersection_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/semaforo_pkg.sv
// Shared state encoding, lamp patterns and duration helper for the intersection sequencer.
package semaforo_pkg;

   typedef enum logic [2:0] {
      RED_A  = 3'd0,
      MAIN_G = 3'd1,
      MAIN_Y = 3'd2,
      RED_B  = 3'd3,
      SIDE_G = 3'd4,
      SIDE_Y = 3'd5,
      FLASH  = 3'd6
   } state_t;

   localparam logic [2:0] LAMP_G   = 3'b100;
   localparam logic [2:0] LAMP_Y   = 3'b010;
   localparam logic [2:0] LAMP_R   = 3'b001;
   localparam logic [2:0] LAMP_OFF = 3'b000;

   // A zero duration would never expire, so it is promoted to one tick.
   function automatic logic [7:0] eff_dur(input int t);
      if (t < 1) begin
         return 8'd1;
      end else if (t > 255) begin
         return 8'd255;
      end else begin
         return 8'(t);
      end
   endfunction

endpackage

// File: rtl/semaforo_tick_gen.sv
// Timing-tick prescaler: one-cycle tick every TICK_DIV clocks, freezable and clearable.
module semaforo_tick_gen #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic hold,
   input  logic clear,
   output logic tick
);
   localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   // Prescaler count, wrapping at TICK_DIV-1.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (hold) begin
         cnt <= cnt;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = !hold && !clear && (cnt == LAST);

endmodule

// File: rtl/semaforo_intersection_ctrl.sv
// Two-way intersection sequencer: FSM, per-state tick timer and registered lamp outputs.
// Night flashing (FLASH state) is built only when SEMAFORO_NIGHT_FLASH_EN is defined.
module semaforo_intersection_ctrl
   import semaforo_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000,
   parameter int GREEN_T  = 10,
   parameter int YELLOW_T = 3,
   parameter int RED_T    = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       side_req,
   input  logic       manual,
   input  logic [2:0] man_main,
   input  logic [2:0] man_side,
   input  logic       night,
   output logic [2:0] main_lamps,
   output logic [2:0] side_lamps,
   output logic       side_ack,
   output logic [2:0] state_o
);
   localparam logic [7:0] GREEN_D  = eff_dur(GREEN_T);
   localparam logic [7:0] YELLOW_D = eff_dur(YELLOW_T);
   localparam logic [7:0] RED_D    = eff_dur(RED_T);

   state_t     state;
   state_t     prev_state;
   logic [7:0] timer;
   logic [7:0] dur;
   logic       manual_q;
   logic       tick;
   logic       expired;
   logic       green_done;
   logic       night_go;

   semaforo_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .hold  (manual),
      .clear (manual_q & ~manual),
      .tick  (tick)
   );

   // Length of the current state in ticks.
   always_comb begin
      dur = RED_D;
      case (state)
         MAIN_G, SIDE_G: dur = GREEN_D;
         MAIN_Y, SIDE_Y: dur = YELLOW_D;
         default:        dur = RED_D;
      endcase
   end

   assign expired    = tick && (timer == dur - 8'd1);
   assign green_done = (timer >= GREEN_D - 8'd1);
   assign state_o    = state;

`ifdef SEMAFORO_NIGHT_FLASH_EN
   logic flash_on;
   assign night_go = night;
`else
   logic unused_night;
   assign unused_night = night;
   assign night_go     = 1'b0;
`endif

   // FSM, tick timer and registered lamp/ack outputs; manual freezes everything but the lamps.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= RED_A;
         prev_state <= RED_A;
         timer      <= 8'd0;
         manual_q   <= 1'b0;
         main_lamps <= LAMP_R;
         side_lamps <= LAMP_R;
         side_ack   <= 1'b0;
`ifdef SEMAFORO_NIGHT_FLASH_EN
         flash_on   <= 1'b0;
`endif
      end else if (manual) begin
         manual_q   <= 1'b1;
         main_lamps <= man_main;
         side_lamps <= man_side;
         side_ack   <= 1'b0;
      end else if (manual_q) begin
         // Restart from clearance; lamps go red at once so a frozen green never reappears.
         manual_q   <= 1'b0;
         state      <= RED_A;
         prev_state <= RED_A;
         timer      <= 8'd0;
         main_lamps <= LAMP_R;
         side_lamps <= LAMP_R;
         side_ack   <= 1'b0;
      end else begin
         prev_state <= state;
         side_ack   <= (state == SIDE_G) && (prev_state != SIDE_G);
         if (tick && !(state == MAIN_G && green_done)) begin
            timer <= timer + 8'd1;
         end
         case (state)
            RED_A: begin
               main_lamps <= LAMP_R;
               side_lamps <= LAMP_R;
               if (expired) begin
                  timer <= 8'd0;
                  state <= night_go ? FLASH : MAIN_G;
`ifdef SEMAFORO_NIGHT_FLASH_EN
                  flash_on <= 1'b1;
`endif
               end
            end
            MAIN_G: begin
               main_lamps <= LAMP_G;
               side_lamps <= LAMP_R;
               if (tick && green_done && side_req) begin
                  timer <= 8'd0;
                  state <= MAIN_Y;
               end
            end
            MAIN_Y: begin
               main_lamps <= LAMP_Y;
               side_lamps <= LAMP_R;
               if (expired) begin
                  timer <= 8'd0;
                  state <= RED_B;
               end
            end
            RED_B: begin
               main_lamps <= LAMP_R;
               side_lamps <= LAMP_R;
               if (expired) begin
                  timer <= 8'd0;
                  state <= night_go ? FLASH : SIDE_G;
`ifdef SEMAFORO_NIGHT_FLASH_EN
                  flash_on <= 1'b1;
`endif
               end
            end
            SIDE_G: begin
               main_lamps <= LAMP_R;
               side_lamps <= LAMP_G;
               if (expired) begin
                  timer <= 8'd0;
                  state <= SIDE_Y;
               end
            end
            SIDE_Y: begin
               main_lamps <= LAMP_R;
               side_lamps <= LAMP_Y;
               if (expired) begin
                  timer <= 8'd0;
                  state <= RED_A;
               end
            end
`ifdef SEMAFORO_NIGHT_FLASH_EN
            FLASH: begin
               main_lamps <= {1'b0, flash_on, 1'b0};
               side_lamps <= {2'b00, flash_on};
               if (tick) begin
                  if (!night) begin
                     timer <= 8'd0;
                     state <= RED_A;
                  end else begin
                     flash_on <= ~flash_on;
                  end
               end
            end
`endif
            default: begin
               main_lamps <= LAMP_R;
               side_lamps <= LAMP_R;
               timer      <= 8'd0;
               state      <= RED_A;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_semaforo_intersection_ctrl.sv
// Self-checking bench: behavioural model compared every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_semaforo_intersection_ctrl;
   import semaforo_pkg::*;

   localparam int DIV = 4;
   localparam int GT  = 3;
   localparam int YT  = 2;
   localparam int RT  = 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       side_req = 1'b0;
   logic       manual = 1'b0;
   logic       night = 1'b0;
   logic [2:0] man_main = 3'b000;
   logic [2:0] man_side = 3'b000;
   logic [2:0] main_lamps;
   logic [2:0] side_lamps;
   logic [2:0] state_o;
   logic       side_ack;

   int tests = 0;
   int fails = 0;
   int acks  = 0;

   semaforo_intersection_ctrl #(
      .TICK_DIV(DIV), .GREEN_T(GT), .YELLOW_T(YT), .RED_T(RT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .side_req(side_req), .manual(manual),
      .man_main(man_main), .man_side(man_side), .night(night),
      .main_lamps(main_lamps), .side_lamps(side_lamps),
      .side_ack(side_ack), .state_o(state_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      tests++;
      if (act !== exp_v) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit         m_valid = 1'b0;
   state_t     m_st = RED_A;
   int         m_pc = 0;
   int         m_ticks = 0;
   bit         m_mq = 1'b0;
   bit         m_just = 1'b0;
   bit         m_fl = 1'b0;
   logic [5:0] e_lamps = 6'b001001;
   logic       e_ack = 1'b0;

   function automatic logic [5:0] lamps_of(input state_t s, input bit fl);
      case (s)
         MAIN_G:  return 6'b100_001;
         MAIN_Y:  return 6'b010_001;
         SIDE_G:  return 6'b001_100;
         SIDE_Y:  return 6'b001_010;
         FLASH:   return {1'b0, fl, 1'b0, 2'b00, fl};
         default: return 6'b001_001;
      endcase
   endfunction

   task automatic model_step();
      bit     tk;
      bit     nf;
      state_t nx;
      nf = 1'b0;
`ifdef SEMAFORO_NIGHT_FLASH_EN
      nf = night;
`endif
      if (!rst_n) begin
         m_valid = 1'b1; m_st = RED_A; m_pc = 0; m_ticks = 0;
         m_mq = 1'b0; m_just = 1'b0; m_fl = 1'b0;
         e_lamps = 6'b001001; e_ack = 1'b0;
         return;
      end
      if (!m_valid) return;
      if (manual) begin
         m_mq = 1'b1; e_lamps = {man_main, man_side}; e_ack = 1'b0;
         return;
      end
      if (m_mq) begin
         m_mq = 1'b0; m_st = RED_A; m_pc = 0; m_ticks = 0; m_just = 1'b0;
         e_lamps = 6'b001001; e_ack = 1'b0;
         return;
      end
      e_lamps = lamps_of(m_st, m_fl);
      e_ack   = m_just;
      m_just  = 1'b0;
      tk      = (m_pc == DIV - 1);
      m_pc    = (m_pc + 1) % DIV;
      if (!tk) return;
      m_ticks++;
      nx = m_st;
      case (m_st)
         RED_A:   if (m_ticks >= RT) nx = nf ? FLASH : MAIN_G;
         MAIN_G:  if (m_ticks >= GT && side_req) nx = MAIN_Y;
         MAIN_Y:  if (m_ticks >= YT) nx = RED_B;
         RED_B:   if (m_ticks >= RT) nx = nf ? FLASH : SIDE_G;
         SIDE_G:  if (m_ticks >= GT) nx = SIDE_Y;
         SIDE_Y:  if (m_ticks >= YT) nx = RED_A;
         FLASH:   if (!night) nx = RED_A; else m_fl = ~m_fl;
         default: nx = RED_A;
      endcase
      if (nx != m_st) begin
         if (nx == SIDE_G) m_just = 1'b1;
         if (nx == FLASH)  m_fl = 1'b1;
         m_st = nx;
         m_ticks = 0;
      end
   endtask

   // Model advances on each edge; DUT outputs compared 1 ns later.
   initial begin
      forever begin
         @(posedge clk);
         model_step();
         #1;
         if (m_valid) begin
            check("cyc_main", 32'(main_lamps), 32'(e_lamps[5:3]));
            check("cyc_side", 32'(side_lamps), 32'(e_lamps[2:0]));
            check("cyc_ack", 32'(side_ack), 32'(e_ack));
            check("cyc_state", 32'(state_o), 32'(m_st));
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_for(input string nm, input logic [5:0] v, input int bound);
      int n;
      n = 0;
      while ({main_lamps, side_lamps} !== v && n < bound) begin
         step();
         n++;
      end
      if ({main_lamps, side_lamps} !== v) begin
         check({nm, "_timeout"}, 32'({main_lamps, side_lamps}), 32'(v));
      end
   endtask

   task automatic run_len(input string nm, input logic [5:0] v, input int exp_len);
      int n;
      wait_for(nm, v, 100);
      n = 0;
      while ({main_lamps, side_lamps} === v && n < 100) begin
         if (side_ack) begin
            acks++;
            side_req = 1'b0;
         end
         n++;
         step();
      end
      check({nm, "_len"}, 32'(n), 32'(exp_len));
   endtask

   task automatic state_len(input string nm, input logic [2:0] s, input int exp_len);
      int n;
      n = 0;
      while (state_o === s && n < 100) begin
         n++;
         step();
      end
      check({nm, "_len"}, 32'(n), 32'(exp_len));
   endtask

   initial begin
      int n;
      repeat (2) step();
      check("rst_main", 32'(main_lamps), 32'(3'b001));
      check("rst_side", 32'(side_lamps), 32'(3'b001));
      check("rst_ack", 32'(side_ack), 32'(1'b0));
      check("rst_state", 32'(state_o), 32'(RED_A));

      rst_n = 1'b1;
      repeat (4) step();
      check("red_a_cycle4", 32'(main_lamps), 32'(3'b001));
      step();
      check("main_g_cycle5", 32'(main_lamps), 32'(3'b100));
      repeat (200) step();
      check("main_g_rest", 32'(main_lamps), 32'(3'b100));
      check("main_g_rest_side", 32'(side_lamps), 32'(3'b001));

      // Full side cycle on a held request.
      side_req = 1'b1;
      run_len("main_y", 6'b010_001, 8);
      run_len("red_b", 6'b001_001, 4);
      run_len("side_g", 6'b001_100, 12);
      run_len("side_y", 6'b001_010, 8);
      run_len("red_a", 6'b001_001, 4);
      check("main_g_back", 32'({main_lamps, side_lamps}), 32'(6'b100_001));
      check("ack_once", 32'(acks), 32'(1));

      // Request withdrawn before green minimum: no change, no ack.
      side_req = 1'b1;
      repeat (3) step();
      side_req = 1'b0;
      repeat (40) step();
      check("withdrawn_main", 32'(main_lamps), 32'(3'b100));
      check("withdrawn_state", 32'(state_o), 32'(MAIN_G));
      check("withdrawn_ack", 32'(acks), 32'(1));

      // Manual override during side green.
      side_req = 1'b1;
      wait_for("side_g2", 6'b001_100, 100);
      side_req = 1'b0;
      step();
      manual = 1'b1; man_main = 3'b010; man_side = 3'b001;
      step();
      check("man_main", 32'(main_lamps), 32'(3'b010));
      check("man_side", 32'(side_lamps), 32'(3'b001));
      check("man_state", 32'(state_o), 32'(SIDE_G));
      repeat (10) step();
      check("man_frozen", 32'(state_o), 32'(SIDE_G));
      check("man_ack", 32'(side_ack), 32'(1'b0));
      manual = 1'b0;
      step();
      check("man_exit_state", 32'(state_o), 32'(RED_A));
      check("man_exit_lamps", 32'({main_lamps, side_lamps}), 32'(6'b001_001));
      state_len("man_exit_red_a", 3'(RED_A), 4);
      check("man_exit_main_g", 32'(state_o), 32'(MAIN_G));

      // Reset in the middle of side yellow.
      side_req = 1'b1;
      wait_for("side_y3", 6'b001_010, 200);
      side_req = 1'b0;
      step();
      rst_n = 1'b0;
      step();
      check("midrst_main", 32'(main_lamps), 32'(3'b001));
      check("midrst_side", 32'(side_lamps), 32'(3'b001));
      check("midrst_ack", 32'(side_ack), 32'(1'b0));
      check("midrst_state", 32'(state_o), 32'(RED_A));
      rst_n = 1'b1;
      repeat (4) step();
      check("midrst_red4", 32'(main_lamps), 32'(3'b001));
      step();
      check("midrst_main_g5", 32'(main_lamps), 32'(3'b100));

`ifdef SEMAFORO_NIGHT_FLASH_EN
      night = 1'b1;
      side_req = 1'b1;
      n = 0;
      while (state_o !== 3'(FLASH) && n < 100) begin
         step();
         n++;
      end
      check("flash_reached", 32'(state_o), 32'(FLASH));
      side_req = 1'b0;
      run_len("flash_on", 6'b010_001, 4);
      run_len("flash_off", 6'b000_000, 4);
      night = 1'b0;
      n = 0;
      while (state_o !== 3'(RED_A) && n < 20) begin
         step();
         n++;
      end
      check("flash_exit", 32'(state_o), 32'(RED_A));
`endif
      repeat (3) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog");
   end

endmodule
